plic_claim_ctrl: RTL and testbench
==================================

// Module: plic_claim_ctrl
// PURPOSE
//  Per-target claim/complete sequencer between the PLIC register file and the PLIC core.
//  Turns bus claim reads and complete writes into single-cycle gateway claim/complete pulses.
//  Keeps a LIFO of in-service {id,prio} so nested (preempting) interrupts are supported.
//  Raises the core's effective threshold to the priority of the interrupt currently in service.
// PARAMETERS
//  IRQ_WIDTH   5  width of interrupt id (`PLIC_IRQ_WIDTH); id 0 = "no interrupt"
//  LEV_WIDTH   3  width of priority level (`PLIC_LEV_WIDTH)
//  NEST_DEPTH  4  max in-service nesting depth (LIFO entries), >=1
//  SETTLE_CYC  2  cycles to block claims after claim/complete (core pipeline refresh)
// PORTS
//  clk_i        in   1          clock
//  rst_i        in   1          reset, asynchronous, active-high
//  core_irq_i   in   1          core winner valid (registered in core)
//  core_id_i    in   IRQ_WIDTH  core winning id
//  core_prio_i  in   LEV_WIDTH  core winning priority
//  thold_i      in   LEV_WIDTH  software threshold register
//  eff_thold_o  out  LEV_WIDTH  threshold driven into core
//  gw_clam_o    out  1          claim pulse to gateway gw_id_o
//  gw_comp_o    out  1          complete pulse to gateway gw_id_o
//  gw_id_o      out  IRQ_WIDTH  gateway select for clam/comp pulse
//  claim_req_i  in   1          bus claim-register read request (level, held until ack)
//  claim_ack_o  out  1          claim done, one cycle
//  claim_id_o   out  IRQ_WIDTH  claimed id, valid with claim_ack_o (0 = none)
//  comp_req_i   in   1          bus complete-register write request (level, held until ack)
//  comp_id_i    in   IRQ_WIDTH  id being completed
//  comp_ack_o   out  1          complete done, one cycle
//  comp_err_o   out  1          complete rejected, valid with comp_ack_o
//  depth_o      out  $clog2(NEST_DEPTH+1)  current nesting depth
//  irq_o        out  1          interrupt to hart (registered)
// BEHAVIOUR
//  Reset: all outputs 0; eff_thold_o follows thold_i; FSM=IDLE; LIFO empty; settle counter 0.
//  FSM IDLE/CLAIM/COMP. Requests only sampled in IDLE; comp_req_i wins over claim_req_i same cycle.
//  Claim accept (IDLE, claim_req_i, settle==0): next state CLAIM.
//   In CLAIM (1 cycle): if core_irq_i && core_id_i!=0 && core_prio_i>eff_thold_o && depth<NEST_DEPTH:
//   push {core_id_i,core_prio_i}, gw_clam_o=1, gw_id_o=core_id_i, claim_ack_o=1, claim_id_o=core_id_i.
//   Else claim_ack_o=1, claim_id_o=0, no pulse, LIFO unchanged. Req->ack latency 2 cycles.
//  Complete (IDLE, comp_req_i): next state COMP. In COMP (1 cycle): comp_ack_o=1.
//   comp_id_i==top id and depth>0: pop, gw_comp_o=1, gw_id_o=comp_id_i, comp_err_o=0.
//   Else (id 0, empty, non-top id): comp_err_o=1, no pulse, LIFO unchanged.
//  Settle: load SETTLE_CYC on every gw_clam_o/gw_comp_o; decrement to 0; claims wait while !=0.
//  eff_thold_o = depth>0 ? max(thold_i, top.prio) : thold_i (combinational from regs).
//  irq_o <= core_irq_i && core_prio_i>eff_thold_o && depth<NEST_DEPTH && settle==0 && state==IDLE.
//  Outputs gw_*, *_ack_o, claim_id_o, comp_err_o registered; pulses exactly one cycle.
//  Full LIFO: no further claim succeeds, irq_o held 0 until a complete.
//  rst_i mid-operation: FSM/LIFO/counter cleared immediately; pending req re-sampled after release.
// STRUCTURE
//  plic_define.sv: PLIC_IRQ_WIDTH/PLIC_LEV_WIDTH reuse; plic_claim_state_e enum (IDLE,CLAIM,COMP);
//   packed struct plic_isv_t {id, prio}.
//  Sub-module plic_claim_stack: NEST_DEPTH-entry LIFO of plic_isv_t; push/pop/top/depth/full/empty;
//   async active-high reset; push+pop never same cycle.
//  plic_claim_ctrl: FSM, settle counter, threshold max, output registers.
// TESTING
//  T1 thold=1, core id=5 prio=3 irq=1, claim_req -> 2 cycles: clam pulse id5, ack id5, depth 1, eff_thold=3.
//  T2 after T1, core id=7 prio=6, claim -> id7 pushed, depth 2, eff_thold=6; complete 5 -> err=1, no pulse.
//  T3 complete 7 then 5 -> two comp pulses ids 7,5, depth 0, eff_thold back to 1, err=0 both.
//  T4 core prio=2 <= eff_thold 3, claim_req -> ack with id 0, no clam pulse, depth unchanged.
//  T5 fill NEST_DEPTH=4 with prios 1..4 -> 5th claim returns 0, irq_o=0; one complete restores irq_o.
//  T6 claim_req+comp_req same cycle -> COMP served first, CLAIM ack follows after settle; rst_i mid-CLAIM -> all 0.

Source files
------------

// File: rtl/plic_claim_ctrl_pkg.sv
// Shared types for the PLIC per-target claim/complete sequencer.
// In-service entries pair an interrupt id with the priority it was claimed at.
package plic_claim_ctrl_pkg;

    localparam int PLIC_IRQ_WIDTH = 5;
    localparam int PLIC_LEV_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLAIM = 2'd1,
        ST_COMP  = 2'd2
    } plic_claim_state_e;

    typedef struct packed {
        logic [PLIC_IRQ_WIDTH-1:0] id;
        logic [PLIC_LEV_WIDTH-1:0] prio;
    } plic_isv_t;

    function automatic logic [PLIC_LEV_WIDTH-1:0] lev_max(
        input logic [PLIC_LEV_WIDTH-1:0] a,
        input logic [PLIC_LEV_WIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/plic_claim_stack.sv
// LIFO of in-service interrupts; the top entry is the one currently being served.
// Push and pop are never requested in the same cycle by the controller.
module plic_claim_stack
    import plic_claim_ctrl_pkg::*;
#(
    parameter  int NEST_DEPTH = 4,
    localparam int DW         = $clog2(NEST_DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  plic_isv_t     push_data_i,
    input  logic          pop_i,
    output plic_isv_t     top_o,
    output logic [DW-1:0] depth_o,
    output logic          full_o,
    output logic          empty_o
);

    plic_isv_t     entries_q [NEST_DEPTH];
    plic_isv_t     entries_d [NEST_DEPTH];
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;

    assign full_o  = (cnt_q == DW'(NEST_DEPTH));
    assign empty_o = (cnt_q == '0);
    assign depth_o = cnt_q;

    always_comb begin
        entries_d = entries_q;
        cnt_d     = cnt_q;
        if (push_i && !full_o) begin
            for (int i = 0; i < NEST_DEPTH; i++) begin
                if (cnt_q == DW'(i)) begin
                    entries_d[i] = push_data_i;
                end
            end
            cnt_d = cnt_q + DW'(1);
        end else if (pop_i && !empty_o) begin
            cnt_d = cnt_q - DW'(1);
        end
    end

    always_comb begin
        top_o = '0;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if (cnt_q == DW'(i + 1)) begin
                top_o = entries_q[i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            entries_q <= '{default: '0};
            cnt_q     <= '0;
        end else begin
            entries_q <= entries_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/plic_claim_ctrl.sv
// Per-target claim/complete sequencer between the PLIC register file and core.
// Raises the core threshold to the priority currently in service (nesting LIFO).
module plic_claim_ctrl
    import plic_claim_ctrl_pkg::*;
#(
    parameter  int IRQ_WIDTH  = PLIC_IRQ_WIDTH,
    parameter  int LEV_WIDTH  = PLIC_LEV_WIDTH,
    parameter  int NEST_DEPTH = 4,
    parameter  int SETTLE_CYC = 2,
    localparam int DW         = $clog2(NEST_DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 core_irq_i,
    input  logic [IRQ_WIDTH-1:0] core_id_i,
    input  logic [LEV_WIDTH-1:0] core_prio_i,
    input  logic [LEV_WIDTH-1:0] thold_i,
    output logic [LEV_WIDTH-1:0] eff_thold_o,
    output logic                 gw_clam_o,
    output logic                 gw_comp_o,
    output logic [IRQ_WIDTH-1:0] gw_id_o,
    input  logic                 claim_req_i,
    output logic                 claim_ack_o,
    output logic [IRQ_WIDTH-1:0] claim_id_o,
    input  logic                 comp_req_i,
    input  logic [IRQ_WIDTH-1:0] comp_id_i,
    output logic                 comp_ack_o,
    output logic                 comp_err_o,
    output logic [DW-1:0]        depth_o,
    output logic                 irq_o
);

    localparam int SW = $clog2(SETTLE_CYC + 2);

    plic_claim_state_e    state_q, state_d;
    logic [SW-1:0]        settle_q, settle_d;
    logic                 clam_q, clam_d;
    logic                 comp_q, comp_d;
    logic [IRQ_WIDTH-1:0] gw_id_q, gw_id_d;
    logic                 claim_ack_q, claim_ack_d;
    logic [IRQ_WIDTH-1:0] claim_id_q, claim_id_d;
    logic                 comp_ack_q, comp_ack_d;
    logic                 comp_err_q, comp_err_d;
    logic                 irq_q, irq_d;

    logic                 push;
    logic                 pop;
    plic_isv_t            push_data;
    plic_isv_t            top;
    logic                 full;
    logic                 empty;
    logic                 claim_ok;
    logic                 comp_ok;
    logic [LEV_WIDTH-1:0] eff_thold;

    assign push_data.id   = core_id_i;
    assign push_data.prio = core_prio_i;

    plic_claim_stack #(
        .NEST_DEPTH (NEST_DEPTH)
    ) u_stack (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .top_o       (top),
        .depth_o     (depth_o),
        .full_o      (full),
        .empty_o     (empty)
    );

    assign eff_thold = empty ? thold_i : lev_max(thold_i, top.prio);

    assign claim_ok = core_irq_i && (core_id_i != '0)
                      && (core_prio_i > eff_thold) && !full;
    assign comp_ok  = !empty && (comp_id_i == top.id);

    always_comb begin
        state_d     = state_q;
        push        = 1'b0;
        pop         = 1'b0;
        clam_d      = 1'b0;
        comp_d      = 1'b0;
        gw_id_d     = '0;
        claim_ack_d = 1'b0;
        claim_id_d  = '0;
        comp_ack_d  = 1'b0;
        comp_err_d  = 1'b0;
        settle_d    = (settle_q != '0) ? settle_q - SW'(1) : '0;

        unique case (state_q)
            ST_IDLE: begin
                // Completes take precedence so a nested handler can unwind.
                if (comp_req_i) begin
                    state_d = ST_COMP;
                end else if (claim_req_i && (settle_q == '0)) begin
                    state_d = ST_CLAIM;
                end
            end
            ST_CLAIM: begin
                state_d     = ST_IDLE;
                claim_ack_d = 1'b1;
                if (claim_ok) begin
                    push       = 1'b1;
                    clam_d     = 1'b1;
                    gw_id_d    = core_id_i;
                    claim_id_d = core_id_i;
                    settle_d   = SW'(SETTLE_CYC);
                end
            end
            ST_COMP: begin
                state_d    = ST_IDLE;
                comp_ack_d = 1'b1;
                if (comp_ok) begin
                    pop      = 1'b1;
                    comp_d   = 1'b1;
                    gw_id_d  = comp_id_i;
                    settle_d = SW'(SETTLE_CYC);
                end else begin
                    comp_err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        irq_d = core_irq_i && (core_prio_i > eff_thold) && !full
                && (settle_q == '0) && (state_q == ST_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            settle_q    <= '0;
            clam_q      <= 1'b0;
            comp_q      <= 1'b0;
            gw_id_q     <= '0;
            claim_ack_q <= 1'b0;
            claim_id_q  <= '0;
            comp_ack_q  <= 1'b0;
            comp_err_q  <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            clam_q      <= clam_d;
            comp_q      <= comp_d;
            gw_id_q     <= gw_id_d;
            claim_ack_q <= claim_ack_d;
            claim_id_q  <= claim_id_d;
            comp_ack_q  <= comp_ack_d;
            comp_err_q  <= comp_err_d;
            irq_q       <= irq_d;
        end
    end

    assign eff_thold_o = eff_thold;
    assign gw_clam_o   = clam_q;
    assign gw_comp_o   = comp_q;
    assign gw_id_o     = gw_id_q;
    assign claim_ack_o = claim_ack_q;
    assign claim_id_o  = claim_id_q;
    assign comp_ack_o  = comp_ack_q;
    assign comp_err_o  = comp_err_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_plic_claim_ctrl.sv
// Scoreboard bench for plic_claim_ctrl: a queue-based in-service model predicts
// every ack; a monitor on the falling edge pops and compares.
module tb_plic_claim_ctrl;

    localparam int IW = 5;
    localparam int LW = 3;
    localparam int ND = 4;
    localparam int DW = $clog2(ND + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          core_irq;
    logic [IW-1:0] core_id;
    logic [LW-1:0] core_prio;
    logic [LW-1:0] thold;
    logic [LW-1:0] eff_thold_o;
    logic          gw_clam_o;
    logic          gw_comp_o;
    logic [IW-1:0] gw_id_o;
    logic          claim_req;
    logic          claim_ack_o;
    logic [IW-1:0] claim_id_o;
    logic          comp_req;
    logic [IW-1:0] comp_id;
    logic          comp_ack_o;
    logic          comp_err_o;
    logic [DW-1:0] depth_o;
    logic          irq_o;

    always #5 clk = ~clk;

    plic_claim_ctrl #(
        .IRQ_WIDTH  (IW),
        .LEV_WIDTH  (LW),
        .NEST_DEPTH (ND),
        .SETTLE_CYC (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .core_irq_i  (core_irq),
        .core_id_i   (core_id),
        .core_prio_i (core_prio),
        .thold_i     (thold),
        .eff_thold_o (eff_thold_o),
        .gw_clam_o   (gw_clam_o),
        .gw_comp_o   (gw_comp_o),
        .gw_id_o     (gw_id_o),
        .claim_req_i (claim_req),
        .claim_ack_o (claim_ack_o),
        .claim_id_o  (claim_id_o),
        .comp_req_i  (comp_req),
        .comp_id_i   (comp_id),
        .comp_ack_o  (comp_ack_o),
        .comp_err_o  (comp_err_o),
        .depth_o     (depth_o),
        .irq_o       (irq_o)
    );

    typedef struct {
        int kind;
        int id;
        int pulse;
        int err;
        int depth;
        int eff;
    } exp_t;

    typedef struct {
        int id;
        int prio;
    } isv_t;

    exp_t exp_q[$];
    isv_t model[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic int m_eff();
        int t = int'(thold);
        if (model.size() == 0) return t;
        return (model[$].prio > t) ? model[$].prio : t;
    endfunction

    function automatic void m_claim();
        exp_t e;
        bit   ok;
        ok = core_irq && (core_id != 0) && (int'(core_prio) > m_eff())
             && (model.size() < ND);
        if (ok) model.push_back('{id: int'(core_id), prio: int'(core_prio)});
        e.kind  = 0;
        e.id    = ok ? int'(core_id) : 0;
        e.pulse = ok;
        e.err   = 0;
        e.depth = model.size();
        e.eff   = m_eff();
        exp_q.push_back(e);
    endfunction

    function automatic void m_comp();
        exp_t e;
        bit   ok;
        ok = (model.size() > 0) && (model[$].id == int'(comp_id));
        if (ok) void'(model.pop_back());
        e.kind  = 1;
        e.id    = ok ? int'(comp_id) : 0;
        e.pulse = ok;
        e.err   = !ok;
        e.depth = model.size();
        e.eff   = m_eff();
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (!rst && (claim_ack_o || comp_ack_o)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ack_kind", int'(comp_ack_o), e.kind);
                if (e.kind == 0) begin
                    check("claim_id", int'(claim_id_o), e.id);
                    check("clam_pulse", int'(gw_clam_o), e.pulse);
                    check("comp_pulse_on_claim", int'(gw_comp_o), 0);
                end else begin
                    check("comp_err", int'(comp_err_o), e.err);
                    check("comp_pulse", int'(gw_comp_o), e.pulse);
                    check("clam_pulse_on_comp", int'(gw_clam_o), 0);
                end
                if (e.pulse) check("gw_id", int'(gw_id_o), e.id);
                check("depth", int'(depth_o), e.depth);
                check("eff_thold", int'(eff_thold_o), e.eff);
            end
        end
        if (!rst && ((gw_clam_o && !claim_ack_o) || (gw_comp_o && !comp_ack_o)))
            check("stray_pulse", 1, 0);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_ack(input bit is_comp, output int cyc);
        cyc = 0;
        forever begin
            tick();
            cyc++;
            if (is_comp ? comp_ack_o : claim_ack_o) return;
            if (cyc > 50) begin
                check(is_comp ? "comp_ack_timeout" : "claim_ack_timeout", 0, 1);
                return;
            end
        end
    endtask

    task automatic do_claim(input bit irq, input int id, input int prio);
        int cyc;
        core_irq  = irq;
        core_id   = IW'(id);
        core_prio = LW'(prio);
        m_claim();
        claim_req = 1'b1;
        wait_ack(1'b0, cyc);
        claim_req = 1'b0;
        check("claim_latency", cyc, 2);
        idle(4);
    endtask

    task automatic do_comp(input int id);
        int cyc;
        comp_id = IW'(id);
        m_comp();
        comp_req = 1'b1;
        wait_ack(1'b1, cyc);
        comp_req = 1'b0;
        check("comp_latency", cyc, 2);
        idle(4);
    endtask

    task automatic check_irq(input string name);
        bit want;
        want = core_irq && (int'(core_prio) > m_eff()) && (model.size() < ND);
        check(name, int'(irq_o), int'(want));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst       = 1'b1;
        core_irq  = 1'b0;
        core_id   = '0;
        core_prio = '0;
        thold     = 3'd5;
        claim_req = 1'b0;
        comp_req  = 1'b0;
        comp_id   = '0;
        idle(2);
        check("rst_claim_ack", int'(claim_ack_o), 0);
        check("rst_comp_ack", int'(comp_ack_o), 0);
        check("rst_gw_clam", int'(gw_clam_o), 0);
        check("rst_gw_comp", int'(gw_comp_o), 0);
        check("rst_depth", int'(depth_o), 0);
        check("rst_irq", int'(irq_o), 0);
        check("rst_eff_thold", int'(eff_thold_o), 5);
        rst = 1'b0;
        thold = 3'd1;
        idle(2);

        // T1 / T2 / T3: nested claims, out-of-order complete, unwinding
        do_claim(1'b1, 5, 3);
        check("t1_eff_thold", int'(eff_thold_o), 3);
        check_irq("t1_irq");
        do_claim(1'b1, 7, 6);
        check("t2_eff_thold", int'(eff_thold_o), 6);
        do_comp(5);
        do_comp(7);
        do_comp(5);
        check("t3_eff_thold", int'(eff_thold_o), 1);

        // T4: priority not above effective threshold
        do_claim(1'b1, 5, 3);
        do_claim(1'b1, 9, 2);
        check_irq("t4_irq");
        do_comp(5);

        // T5: fill the LIFO, then one complete reopens irq
        thold = 3'd0;
        for (int i = 1; i <= ND; i++) do_claim(1'b1, i, i);
        do_claim(1'b1, 9, 7);
        check_irq("t5_irq_full");
        check("t5_irq_full_direct", int'(irq_o), 0);
        do_comp(4);
        check_irq("t5_irq_after_comp");
        for (int i = 3; i >= 1; i--) do_comp(i);

        // T6: simultaneous requests; complete first, claim after settle
        do_claim(1'b1, 6, 5);
        core_id   = 5'd8;
        core_prio = 3'd6;
        comp_id   = 5'd6;
        m_comp();
        m_claim();
        comp_req  = 1'b1;
        claim_req = 1'b1;
        wait_ack(1'b1, cyc);
        comp_req  = 1'b0;
        wait_ack(1'b0, cyc);
        claim_req = 1'b0;
        check("t6_claim_waited_settle", int'(cyc > 2), 1);
        idle(4);

        // T6: reset in the middle of a claim
        core_id   = 5'd10;
        core_prio = 3'd7;
        claim_req = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        check("midrst_claim_ack", int'(claim_ack_o), 0);
        check("midrst_gw_clam", int'(gw_clam_o), 0);
        check("midrst_depth", int'(depth_o), 0);
        check("midrst_irq", int'(irq_o), 0);
        check("midrst_eff_thold", int'(eff_thold_o), int'(thold));
        model.delete();
        idle(2);
        rst = 1'b0;
        m_claim();
        wait_ack(1'b0, cyc);
        claim_req = 1'b0;
        check("rearm_latency", cyc, 2);
        idle(4);
        do_comp(10);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            thold = LW'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                do_claim(($urandom_range(0, 7) != 0), $urandom_range(0, 31),
                         $urandom_range(0, 7));
            end else if (model.size() > 0 && $urandom_range(0, 3) != 0) begin
                do_comp(model[$].id);
            end else begin
                do_comp($urandom_range(0, 31));
            end
            check_irq("rand_irq");
        end

        idle(3);
        check("scoreboard_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
